// File: rtl/vending_pkg.sv
// Shared vending-machine types: coin encodings and values, dispenser FSM states, drink codes.
package vending_pkg;

    typedef enum logic [1:0] {
        COIN_NONE = 2'b00,
        COIN_ONE  = 2'b01,
        COIN_FIVE = 2'b10,
        COIN_TEN  = 2'b11
    } coin_t;

    localparam int unsigned ONE_VAL  = 1;
    localparam int unsigned FIVE_VAL = 5;
    localparam int unsigned TEN_VAL  = 10;

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        ISSUE,
        DONE
    } disp_state_t;

    typedef enum logic [1:0] {
        DRINK_NONE  = 2'b00,
        DRINK_WATER = 2'b01,
        DRINK_SODA  = 2'b10,
        DRINK_JUICE = 2'b11
    } drink_t;

    function automatic int unsigned coin_value(input coin_t c);
        case (c)
            COIN_ONE:  return ONE_VAL;
            COIN_FIVE: return FIVE_VAL;
            COIN_TEN:  return TEN_VAL;
            default:   return 0;
        endcase
    endfunction

endpackage

// File: rtl/coin_stock_counter.sv
// Stock of one coin denomination: saturating refill add with an optional
// simultaneous single-coin decrement.
module coin_stock_counter #(
    parameter int CNT_W = 8,
    parameter int INIT  = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             refill,
    input  logic [CNT_W-1:0] refill_count,
    input  logic             dec,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg, count_next;
    logic [CNT_W:0]   base, sum;

    // One extra bit catches overflow of stock + refill; the decrement is
    // applied before clamping so a full counter plus refill minus one stays full.
    always_comb begin
        base = {1'b0, count_reg} + (refill ? {1'b0, refill_count} : '0);
        sum  = base;
        if (dec && (base != '0)) begin
            sum = base - (CNT_W + 1)'(1);
        end
        count_next = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= CNT_W'(INIT);
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/change_dispenser.sv
// Pays out a change amount coin by coin (greedy 10/5/1, limited by stock) over a
// valid/ack hopper handshake. Optional CHANGE_TIMEOUT_EN abandons an un-acked coin.
module change_dispenser
    import vending_pkg::*;
#(
    parameter int CHANGE_W       = 5,
    parameter int CNT_W          = 8,
    parameter int INIT_TENS      = 20,
    parameter int INIT_FIVES     = 20,
    parameter int INIT_ONES      = 20,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                change_valid_i,
    input  logic [CHANGE_W-1:0] change_i,
    output logic                busy_o,
    output logic                coin_valid_o,
    output logic [1:0]          coin_type_o,
    input  logic                coin_ack_i,
    output logic                done_o,
    output logic                short_o,
    output logic [CHANGE_W-1:0] remaining_o,
    input  logic                refill_i,
    input  logic [1:0]          refill_type_i,
    input  logic [CNT_W-1:0]    refill_count_i,
    output logic [CNT_W-1:0]    stock_tens_o,
    output logic [CNT_W-1:0]    stock_fives_o,
    output logic [CNT_W-1:0]    stock_ones_o
);

    disp_state_t         state_reg, state_next;
    logic [CHANGE_W-1:0] remaining_reg, remaining_next;
    coin_t               coin_reg, coin_next;
    logic                short_reg, short_next;
    logic [2:0]          dec;           // index = coin code - 1: one, five, ten
    logic [CNT_W-1:0]    stock [3];
    logic [CHANGE_W-1:0] coin_amount;
    logic                timeout_hit;

    assign coin_amount = CHANGE_W'(coin_value(coin_reg));

`ifdef CHANGE_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] timer_reg;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            timer_reg <= '0;
        end else if (state_reg != ISSUE) begin
            timer_reg <= '0;
        end else if (timer_reg != TMR_W'(TIMEOUT_CYCLES - 1)) begin
            timer_reg <= timer_reg + TMR_W'(1);
        end
    end

    assign timeout_hit = (state_reg == ISSUE) && (timer_reg == TMR_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        coin_next      = coin_reg;
        short_next     = short_reg;
        dec            = '0;
        case (state_reg)
            IDLE: begin
                if (change_valid_i) begin
                    remaining_next = change_i;
                    short_next     = 1'b0;
                    state_next     = SELECT;
                end
            end
            SELECT: begin
                if (remaining_reg == '0) begin
                    state_next = DONE;
                end else if ((remaining_reg >= CHANGE_W'(TEN_VAL)) && (stock[2] != '0)) begin
                    coin_next  = COIN_TEN;
                    state_next = ISSUE;
                end else if ((remaining_reg >= CHANGE_W'(FIVE_VAL)) && (stock[1] != '0)) begin
                    coin_next  = COIN_FIVE;
                    state_next = ISSUE;
                end else if ((remaining_reg >= CHANGE_W'(ONE_VAL)) && (stock[0] != '0)) begin
                    coin_next  = COIN_ONE;
                    state_next = ISSUE;
                end else begin
                    short_next = 1'b1;
                    state_next = DONE;
                end
            end
            ISSUE: begin
                if (coin_ack_i) begin
                    remaining_next = remaining_reg - coin_amount;
                    dec            = {coin_reg == COIN_TEN, coin_reg == COIN_FIVE, coin_reg == COIN_ONE};
                    state_next     = SELECT;
                end else if (timeout_hit) begin
                    // The abandoned coin stays in remaining and in stock.
                    short_next = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
            coin_reg      <= COIN_NONE;
            short_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            coin_reg      <= coin_next;
            short_reg     <= short_next;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_stock
            coin_stock_counter #(
                .CNT_W (CNT_W),
                .INIT  ((gi == 0) ? INIT_ONES : ((gi == 1) ? INIT_FIVES : INIT_TENS))
            ) u_counter (
                .clk          (clk_i),
                .rst_n        (rst_i),
                .refill       (refill_i && (refill_type_i == 2'(gi + 1))),
                .refill_count (refill_count_i),
                .dec          (dec[gi]),
                .count        (stock[gi])
            );
        end
    endgenerate

    assign busy_o        = (state_reg != IDLE);
    assign coin_valid_o  = (state_reg == ISSUE);
    assign coin_type_o   = coin_valid_o ? coin_reg : COIN_NONE;
    assign done_o        = (state_reg == DONE);
    assign short_o       = done_o && short_reg;
    assign remaining_o   = remaining_reg;
    assign stock_ones_o  = stock[0];
    assign stock_fives_o = stock[1];
    assign stock_tens_o  = stock[2];

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: stimulus queues expected coins and done
// results, a monitor checks them as the DUT presents handshakes and done pulses.
module tb_change_dispenser;
    import vending_pkg::*;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       change_valid_i;
    logic [4:0] change_i;
    logic       busy_o, coin_valid_o, coin_ack_i, done_o, short_o;
    logic [1:0] coin_type_o;
    logic [4:0] remaining_o;
    logic       refill_i;
    logic [1:0] refill_type_i;
    logic [7:0] refill_count_i;
    logic [7:0] stock_tens_o, stock_fives_o, stock_ones_o;

    typedef struct {
        logic        shrt;
        logic [31:0] rem;
    } done_exp_t;

    coin_t     coin_q[$];
    done_exp_t done_q[$];
    int        checks = 0;
    int        errors = 0;
    int        ack_delay = 0;
    bit        no_ack = 1'b0;
    int        hop_wait = 0;
    logic      prev_valid = 1'b0;
    logic      prev_ack = 1'b0;
    logic [1:0] prev_type = 2'b00;
    coin_t     mon_coin;
    done_exp_t mon_done;

    always #5 clk = ~clk;

    change_dispenser dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .change_valid_i (change_valid_i),
        .change_i       (change_i),
        .busy_o         (busy_o),
        .coin_valid_o   (coin_valid_o),
        .coin_type_o    (coin_type_o),
        .coin_ack_i     (coin_ack_i),
        .done_o         (done_o),
        .short_o        (short_o),
        .remaining_o    (remaining_o),
        .refill_i       (refill_i),
        .refill_type_i  (refill_type_i),
        .refill_count_i (refill_count_i),
        .stock_tens_o   (stock_tens_o),
        .stock_fives_o  (stock_fives_o),
        .stock_ones_o   (stock_ones_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_stock(input string tag, input int t, input int f, input int o);
        check({tag, "_tens"}, stock_tens_o, t);
        check({tag, "_fives"}, stock_fives_o, f);
        check({tag, "_ones"}, stock_ones_o, o);
        $display("stock after %s: tens=%0d fives=%0d ones=%0d", tag, stock_tens_o, stock_fives_o, stock_ones_o);
    endtask

    // n counts falling edges after the strobe is sampled, including the done cycle.
    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (n < limit) begin
            @(negedge clk);
            n++;
            if (done_o) break;
        end
        if (!done_o) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done_o within %0d cycles, required a pulse", limit);
            n = -1;
        end
        tick();
        check("busy_after_done", busy_o, 0);
        check("coin_type_idle", coin_type_o, 0);
    endtask

    task automatic expect_pay(input int amt, input bit shrt, input int rem,
                              input coin_t c0, input coin_t c1, input coin_t c2, input coin_t c3);
        done_exp_t d;
        if (c0 != COIN_NONE) coin_q.push_back(c0);
        if (c1 != COIN_NONE) coin_q.push_back(c1);
        if (c2 != COIN_NONE) coin_q.push_back(c2);
        if (c3 != COIN_NONE) coin_q.push_back(c3);
        d.shrt = shrt;
        d.rem  = rem;
        done_q.push_back(d);
        change_i       = 5'(amt);
        change_valid_i = 1'b1;
        tick();
        change_valid_i = 1'b0;
    endtask

    task automatic pay(input int amt, input bit shrt, input int rem,
                       input coin_t c0, input coin_t c1, input coin_t c2, input coin_t c3,
                       output int n);
        expect_pay(amt, shrt, rem, c0, c1, c2, c3);
        wait_done(400, n);
        $display("payout %0d: short=%0d remaining=%0d cycles=%0d", amt, short_o, remaining_o, n);
    endtask

    // Hopper model: acks a presented coin after ack_delay further cycles.
    initial begin
        coin_ack_i = 1'b0;
        forever begin
            tick();
            if (coin_valid_o && !coin_ack_i && !no_ack) begin
                if (hop_wait >= ack_delay) begin
                    coin_ack_i = 1'b1;
                    hop_wait   = 0;
                end else begin
                    hop_wait++;
                end
            end else begin
                coin_ack_i = 1'b0;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_i) begin
                if (prev_valid && !prev_ack && coin_valid_o)
                    check("coin_type_stable", coin_type_o, prev_type);
                if (coin_valid_o && coin_ack_i) begin
                    if (coin_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_coin: got type %0d, required no coin", coin_type_o);
                    end else begin
                        mon_coin = coin_q.pop_front();
                        check("coin_type", coin_type_o, mon_coin);
                        $display("coin dispensed: type=%0d expected=%0d", coin_type_o, mon_coin);
                    end
                end
                if (short_o && !done_o)
                    check("short_without_done", short_o, 0);
                if (done_o) begin
                    if (done_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done_o=1, required no done");
                    end else begin
                        mon_done = done_q.pop_front();
                        check("short", short_o, mon_done.shrt);
                        check("remaining", remaining_o, mon_done.rem);
                        check("busy_at_done", busy_o, 1);
                        check("coins_outstanding", coin_q.size(), 0);
                    end
                end
                prev_valid = coin_valid_o;
                prev_ack   = coin_ack_i;
                prev_type  = coin_type_o;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_i          = 1'b0;
        change_valid_i = 1'b0;
        change_i       = '0;
        refill_i       = 1'b0;
        refill_type_i  = 2'b00;
        refill_count_i = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy_o, 0);
        check("rst_coin_valid", coin_valid_o, 0);
        check("rst_done", done_o, 0);
        check("rst_short", short_o, 0);
        check("rst_coin_type", coin_type_o, 0);
        check("rst_remaining", remaining_o, 0);
        check_stock("reset", 20, 20, 20);
        tick();
        rst_i = 1'b1;
        tick();

        // 16 with immediate ack: ten, five, one at 2 cycles per coin.
        pay(16, 0, 0, COIN_TEN, COIN_FIVE, COIN_ONE, COIN_NONE, n);
        check("latency_16", n, 8);
        check_stock("pay16", 19, 19, 19);

        // Zero change: no coin, done two cycles after the strobe.
        pay(0, 0, 0, COIN_NONE, COIN_NONE, COIN_NONE, COIN_NONE, n);
        check("latency_zero", n, 2);

        // Slow hopper, plus a strobe during busy that must be dropped.
        ack_delay = 5;
        expect_pay(6, 0, 0, COIN_FIVE, COIN_ONE, COIN_NONE, COIN_NONE);
        repeat (3) tick();
        check("busy_mid_payout", busy_o, 1);
        change_i       = 5'd7;
        change_valid_i = 1'b1;
        tick();
        change_valid_i = 1'b0;
        wait_done(400, n);
        repeat (6) tick();
        check("busy_after_ignored", busy_o, 0);
        check_stock("pay6", 19, 18, 18);
        ack_delay = 0;

        // Saturating refill, then a refill of type 00 that must change nothing.
        refill_i       = 1'b1;
        refill_type_i  = 2'b10;
        refill_count_i = 8'd255;
        tick();
        refill_type_i  = 2'b00;
        refill_count_i = 8'd5;
        tick();
        refill_i = 1'b0;
        check_stock("refill", 19, 255, 18);

        // Drain tens down to one.
        for (int i = 0; i < 6; i++)
            pay(30, 0, 0, COIN_TEN, COIN_TEN, COIN_TEN, COIN_NONE, n);
        check_stock("drain_tens", 1, 255, 18);

        // Last ten, then fives stand in for the missing ten.
        pay(20, 0, 0, COIN_TEN, COIN_FIVE, COIN_FIVE, COIN_NONE, n);
        pay(10, 0, 0, COIN_FIVE, COIN_FIVE, COIN_NONE, COIN_NONE, n);
        check_stock("no_tens", 0, 251, 18);

        // Refill of ones landing on the same edge as a ones ack: 18 + 2 - 1.
        ack_delay = 2;
        expect_pay(1, 0, 0, COIN_ONE, COIN_NONE, COIN_NONE, COIN_NONE);
        n = 0;
        while (!(coin_valid_o && coin_ack_i) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ack_seen_for_refill", coin_ack_i, 1);
        refill_i       = 1'b1;
        refill_type_i  = 2'b01;
        refill_count_i = 8'd2;
        tick();
        refill_i = 1'b0;
        wait_done(400, n);
        ack_delay = 0;
        check_stock("refill_and_dec", 0, 251, 19);

        // Drain ones down to one, then shortfalls.
        for (int i = 0; i < 4; i++)
            pay(4, 0, 0, COIN_ONE, COIN_ONE, COIN_ONE, COIN_ONE, n);
        pay(2, 0, 0, COIN_ONE, COIN_ONE, COIN_NONE, COIN_NONE, n);
        check_stock("drain_ones", 0, 251, 1);
        pay(3, 1, 2, COIN_ONE, COIN_NONE, COIN_NONE, COIN_NONE, n);
        check("remaining_held", remaining_o, 2);
        pay(12, 1, 2, COIN_FIVE, COIN_FIVE, COIN_NONE, COIN_NONE, n);
        check_stock("shortfall", 0, 249, 0);

`ifdef CHANGE_TIMEOUT_EN
        // Hopper never acks: coin abandoned after the timeout, stock untouched.
        no_ack = 1'b1;
        pay(5, 1, 5, COIN_NONE, COIN_NONE, COIN_NONE, COIN_NONE, n);
        check("timeout_latency", n, 66);
        no_ack = 1'b0;
        check_stock("timeout", 0, 249, 0);
`endif

        repeat (4) tick();
        check("coin_queue_drained", coin_q.size(), 0);
        check("done_queue_drained", done_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
